// File: rtl/seq_det_pkg.sv
// Shared encodings for the 1011 detector and the scheduler controller.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } fsm_t;

endpackage

// File: rtl/mealy_1011_step.sv
// One combinational step of the overlapping Mealy 1011 detector.
module mealy_1011_step
    import seq_det_pkg::*;
(
    input  logic [1:0] state,
    input  logic       bit_in,
    output logic [1:0] nxt,
    output logic       match
);

    det_t n;

    always_comb begin
        n     = S0;
        match = 1'b0;
        unique case (det_t'(state))
            S0: n = bit_in ? S1 : S0;
            S1: n = bit_in ? S1 : S2;
            S2: n = bit_in ? S3 : S0;
            S3: begin
                n     = bit_in ? S1 : S2;
                match = bit_in;
            end
        endcase
    end

    assign nxt = n;

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler time-sharing one 1011 detector across channels,
// with per-channel detector context and saturating match counters.
module seq_detect_scheduler
    import seq_det_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         req,
    input  logic [8*N_CH-1:0]       data,
    output logic [N_CH-1:0]         ack,
    output logic                    busy,
    output logic                    match_valid,
    output logic [$clog2(N_CH)-1:0] match_ch,
    output logic [CNT_W*N_CH-1:0]   match_cnt
);

    localparam int CH_W = $clog2(N_CH);

    fsm_t             state, nstate;
    logic [CH_W-1:0]  last, g, gnt;
    logic             found;
    logic [7:0]       sh;
    logic [2:0]       bidx;
    det_t             det;
    det_t             ctx [N_CH];
    logic [CNT_W-1:0] cnt [N_CH];
    logic [1:0]       step_nxt;
    logic             hit;

    mealy_1011_step u_step (
        .state  (det),
        .bit_in (sh[bidx]),
        .nxt    (step_nxt),
        .match  (hit)
    );

    // Search starts one past the last grant so every requester is reached.
    always_comb begin
        found = 1'b0;
        gnt   = last;
        for (int k = 1; k <= N_CH; k++) begin
            if (!found && req[(int'(last) + k) % N_CH]) begin
                found = 1'b1;
                gnt   = CH_W'((int'(last) + k) % N_CH);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (found) nstate = SHIFT;
            SHIFT: if (bidx == 3'd0) nstate = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last        <= CH_W'(N_CH - 1);
            g           <= '0;
            sh          <= '0;
            bidx        <= 3'd7;
            det         <= S0;
            ack         <= '0;
            match_valid <= 1'b0;
            match_ch    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ctx[i] <= S0;
                cnt[i] <= '0;
            end
        end else begin
            ack         <= '0;
            match_valid <= 1'b0;
            if (state == IDLE && found) begin
                g        <= gnt;
                last     <= gnt;
                sh       <= data[8*gnt +: 8];
                ack[gnt] <= 1'b1;
                det      <= ctx[gnt];
                bidx     <= 3'd7;
            end else if (state == SHIFT) begin
                det <= det_t'(step_nxt);
                if (hit) begin
                    match_valid <= 1'b1;
                    match_ch    <= g;
                    if (cnt[g] != '1) cnt[g] <= cnt[g] + 1'b1;
                end
                if (bidx == 3'd0) ctx[g] <= det_t'(step_nxt);
                else              bidx   <= bidx - 3'd1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        assign match_cnt[CNT_W*i +: CNT_W] = cnt[i];
    end

endmodule
